// File: rtl/alu_pkg.sv
// Shared ALU/divider definitions: funct codes, default datapath width and divider state encoding.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] FN_MFHI = 6'd16;
  localparam logic [5:0] FN_MFLO = 6'd18;
  localparam logic [5:0] FN_DIV  = 6'd26;
  localparam logic [5:0] FN_DIVU = 6'd27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divu_hilo.sv
// Hi/Lo result register pair with the registered MFHI/MFLO readback port.
module divu_hilo
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  // A read in the same cycle as a write sees the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_reg  <= '0;
      lo_reg  <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        hi_reg <= hi_in;
        lo_reg <= lo_in;
      end
      if (rd_hi) begin
        rd_data <= hi_reg;
      end else if (rd_lo) begin
        rd_data <= lo_reg;
      end
    end
  end

endmodule

// File: rtl/divu_unit.sv
// Sequential restoring divider, one quotient bit per clock; results land in divu_hilo.
// Optional signed DIV support is enabled with DIVU_SIGNED_EN.
module divu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] Output,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       state_reg, state_next;
  logic [WIDTH:0]   rem_reg, rem_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] div_reg, div_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic             start;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] lo_res, hi_res;
  logic [WIDTH:0]   rem_shift, rem_iter;
  logic [WIDTH-1:0] q_iter;

`ifdef DIVU_SIGNED_EN
  logic neg_q_reg, neg_q_next;
  logic neg_r_reg, neg_r_next;
  logic sgn_a, sgn_b;

  assign start  = (Signal == FN_DIVU) || (Signal == FN_DIV);
  assign sgn_a  = (Signal == FN_DIV) && dataA[WIDTH-1];
  assign sgn_b  = (Signal == FN_DIV) && dataB[WIDTH-1];
  assign a_mag  = sgn_a ? (~dataA + WIDTH'(1)) : dataA;
  assign b_mag  = sgn_b ? (~dataB + WIDTH'(1)) : dataB;
  assign lo_res = neg_q_reg ? (~q_reg + WIDTH'(1)) : q_reg;
  assign hi_res = neg_r_reg ? (~rem_reg[WIDTH-1:0] + WIDTH'(1)) : rem_reg[WIDTH-1:0];
`else
  assign start  = (Signal == FN_DIVU);
  assign a_mag  = dataA;
  assign b_mag  = dataB;
  assign lo_res = q_reg;
  assign hi_res = rem_reg[WIDTH-1:0];
`endif

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    q_iter    = {q_reg[WIDTH-2:0], 1'b0};
    rem_iter  = rem_shift;
    if (rem_shift >= {1'b0, div_reg}) begin
      rem_iter  = rem_shift - {1'b0, div_reg};
      q_iter[0] = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    q_next     = q_reg;
    div_next   = div_reg;
    cnt_next   = cnt_reg;
`ifdef DIVU_SIGNED_EN
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          q_next     = a_mag;
          div_next   = b_mag;
          rem_next   = '0;
          cnt_next   = '0;
`ifdef DIVU_SIGNED_EN
          // A zero divisor keeps the all-ones quotient unsigned-style.
          neg_q_next = (sgn_a ^ sgn_b) && (dataB != '0);
          neg_r_next = sgn_a;
`endif
        end
      end
      RUN: begin
        rem_next = rem_iter;
        q_next   = q_iter;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST_CNT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      q_reg     <= '0;
      div_reg   <= '0;
      cnt_reg   <= '0;
`ifdef DIVU_SIGNED_EN
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      q_reg     <= q_next;
      div_reg   <= div_next;
      cnt_reg   <= cnt_next;
`ifdef DIVU_SIGNED_EN
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
`endif
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);

  divu_hilo #(
    .WIDTH(WIDTH)
  ) u_hilo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (state_reg == DONE),
    .hi_in  (hi_res),
    .lo_in  (lo_res),
    .rd_hi  (Signal == FN_MFHI),
    .rd_lo  (Signal == FN_MFLO),
    .rd_data(Output)
  );

endmodule

// File: doc/divu_unit.md
Name: divu_unit

Overview:
- Sequential unsigned 32-bit divider; the inverse-direction companion to the ALU's MULTU path.
- Accepts a DIVU request on the same Signal/dataA/dataB bus as the ALU.
- Runs restoring shift-subtract, one quotient bit per clock.
- Leaves quotient in Lo and remainder in Hi, read back with MFHI/MFLO on that bus.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- Signal  input  6  funct code: DIVU=27, MFHI=16, MFLO=18; all other codes are ignored by this block.
- dataA  input  WIDTH  dividend; sampled at start.
- dataB  input  WIDTH  divisor; sampled at start.
- Output  output  WIDTH  registered Hi/Lo readback.
- busy  output  1  high while dividing.
- done  output  1  one-cycle pulse when Hi/Lo are updated.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; Hi=0, Lo=0, Output=0, busy=0, done=0, counter=0; internal remainder and quotient=0.
  - Reset during RUN aborts the operation; no partial result reaches Hi/Lo.
- States:
  - IDLE -> RUN when Signal==27 at a rising edge. Latch dataA into the quotient shift register and dataB into the divisor register; clear the (WIDTH+1)-bit partial remainder; counter=0; busy=1.
  - RUN, each cycle:
    - rem = {rem[WIDTH-1:0], q[WIDTH-1]}; q = q<<1.
    - If rem >= {0,divisor}: rem -= divisor; q[0]=1.
    - counter++.
    - After WIDTH iterations, go to DONE.
  - DONE (one cycle): Lo<=q, Hi<=rem[WIDTH-1:0], done=1, busy=0; go to IDLE.
- Latency: start edge + 32 RUN cycles + 1 DONE cycle. Hi/Lo are valid 33 cycles after the start edge, within the 33-cycle wait the bench uses for MULTU.
- Requests while busy: Signal==27 in RUN or DONE is ignored (no restart, no queue). MFHI/MFLO in RUN return the previous Hi/Lo.
- Readback:
  - Output<=Hi when Signal==16; Output<=Lo when Signal==18 (one-cycle latency).
  - Otherwise Output holds its value.
  - MFHI/MFLO in the DONE cycle returns the old value; the new value is visible from the next request onward.
- Divide by zero (dataB==0): still runs the full 32 cycles. Result is Lo=0xFFFFFFFF, Hi=dataA; this falls out naturally from the algorithm and must not be special-cased differently.
- Dividend < divisor: Lo=0, Hi=dataA.
- Hi/Lo hold their values indefinitely until the next DONE or reset.

Optional Feature:
- Macro: DIVU_SIGNED_EN.
- Defined:
  - Signal==26 (DIV) is also accepted as a start.
  - Operands are converted to magnitudes at start and the signs latched.
  - In DONE, the quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - Divide by zero: Lo=0xFFFFFFFF, Hi=dataA unmodified.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0.
  - Latency is unchanged.
- Undefined: code 26 is ignored like any unknown code; no sign logic is synthesized.

Decomposition:
- Shared package alu_pkg: funct constants FN_DIVU=27, FN_DIV=26, FN_MFHI=16, FN_MFLO=18 (also reused by the ALU's MULTU/MFHI/MFLO decode), WIDTH default, and state encoding IDLE/RUN/DONE.
- One sub-module, divu_hilo: the Hi/Lo register pair plus the MFHI/MFLO readback register. It is shared-shape with the multiplier's Hi/Lo so the two can later be merged.
- The iteration datapath stays in divu_unit.

Test Plan:
- DIVU 100, 7 -> busy for 32 cycles, done at cycle 33; MFHI -> 2, MFLO -> 14.
- DIVU 4294967295, 1 -> MFHI 0, MFLO 4294967295; then DIVU 3, 10 -> MFHI 3, MFLO 0.
- DIVU 5, 0 -> MFLO 4294967295, MFHI 5, after the full 33 cycles.
- DIVU 100, 7, then DIVU 9, 3 issued at cycle 10 -> second request ignored; result still Hi=2, Lo=14. MFLO during RUN returns the prior Lo.
- DIVU 1000, 3 with reset pulsed low at cycle 15 -> Hi=Lo=Output=0, busy=0 immediately; no done pulse. A fresh DIVU 1000, 3 then gives Hi=1, Lo=333.
- DIVU_SIGNED_EN only: DIV -7, 2 -> Lo=-3, Hi=-1; DIV 0x80000000, 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
